lfsr_seed_stepper: RTL
======================

// Module: lfsr_seed_stepper
// PURPOSE
//  Sequential upstream stage for the combinational LFSR/probability-mask step.
//  Holds the current seed register, presents it on out_seed and captures the
//  step result (rnd_in) on each accepted transfer, producing a burst of
//  load_count successive seeds under a valid/ready handshake.
// PARAMETERS
//  RND_SIZE     5       base size; seed width SEED_W = RND_SIZE*(RND_SIZE-1)/2 (10)
//  CNT_W        8       width of burst length counter
//  DEFAULT_SEED 'h001   substituted for an all-zero load_seed; also reset value
//  PROB_DEFAULT 2'b00   probability select driven when latch feature is compiled out
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       synchronous, active-high reset
//  load_valid  in   1       load request
//  load_ready  out  1       high only in IDLE
//  load_seed   in   SEED_W  initial seed
//  load_count  in   CNT_W   number of seeds to emit (0 allowed)
//  prob_in     in   2       probability select captured at load (feature only)
//  prob_out    out  2       probability select for the downstream step
//  out_valid   out  1       out_seed valid
//  out_ready   in   1       downstream accepts out_seed
//  out_seed    out  SEED_W  current seed register
//  rnd_in      in   SEED_W  step result computed from out_seed (combinational downstream)
//  abort       in   1       cancel burst
//  busy        out  1       FSM != IDLE
//  done        out  1       one-cycle pulse at burst completion
// BEHAVIOUR
//  - Reset: FSM=IDLE, seed_q=DEFAULT_SEED, remaining=0, out_valid=0, done=0,
//    busy=0, load_ready=1 on first cycle after reset, prob_out=PROB_DEFAULT.
//  - FSM IDLE/RUN/DONE. out_valid=(RUN), done=(DONE), load_ready=(IDLE).
//  - IDLE: load_valid&&load_ready -> seed_q<=(load_seed==0 ? DEFAULT_SEED : load_seed),
//    remaining<=load_count; next RUN if load_count!=0, else DONE.
//  - RUN: out_seed=seed_q. On out_valid&&out_ready: seed_q<=rnd_in, remaining-=1;
//    if remaining==1 -> DONE. Without handshake: seed_q, remaining held (stall-stable).
//  - DONE: done=1 for exactly one cycle, then IDLE. Handshake at T -> done at T+1,
//    load_ready at T+2. Count 0: load at T -> done at T+1, no out_valid.
//  - abort in RUN: next state IDLE, no done pulse; abort beats handshake in the same
//    cycle (transfer is consumed downstream, seed_q/remaining not updated).
//    abort in IDLE/DONE ignored.
//  - rst mid-burst: returns to reset values next cycle, no done pulse.
//  - rnd_in sampled only on handshake; no combinational path rnd_in -> outputs.
//  - Width: remaining is CNT_W bits, never wraps (decrement only when >=1).
// CONFIGURATION
//  - LFSR_STEP_PROB_LATCH_EN defined: prob_in captured into prob_q on accepted load;
//    prob_out=prob_q, stable for the whole burst; reset value PROB_DEFAULT.
//  - Not defined: prob_in ignored, prob_out tied to PROB_DEFAULT, no prob_q register.
// TESTING (RND_SIZE=5, bench model rnd_in = out_seed ^ 10'h3FF)
//  - Reset 3 cycles -> out_valid=0, done=0, busy=0, out_seed=10'h001, load_ready=1.
//  - Load 10'h2A5, count 3, out_ready=1 -> out_seed 2A5,15A,2A5 on 3 consecutive
//    cycles; done=1 one cycle after third; load_ready=1 the cycle after that.
//  - Same load, out_ready low 5 cycles after first beat -> out_seed=10'h15A held,
//    out_valid=1; total beats still 3, single done pulse.
//  - Load seed 10'h000, count 1 -> single beat with out_seed=10'h001; count 0 ->
//    no out_valid, done=1 exactly one cycle, cycle after load.
//  - Abort asserted with handshake on beat 2 of count 5 -> IDLE next cycle, no done,
//    seed_q=10'h15A; rst asserted mid-burst -> all outputs at reset values.
//  - Macro defined: load with prob_in=2'b10, then change prob_in -> prob_out=2'b10
//    all burst; macro undefined -> prob_out=2'b00 always.

Source files
------------

// File: rtl/lfsr_seed_stepper_if.sv
// Handshake/data bundle between the seed stepper (slave) and its load/step environment (master).
// Carries the load request, the seed burst output, the step result return path and status.
interface lfsr_seed_stepper_if #(
    parameter int SEED_W = 10,
    parameter int CNT_W  = 8
);
    logic              load_valid;
    logic              load_ready;
    logic [SEED_W-1:0] load_seed;
    logic [CNT_W-1:0]  load_count;
    logic [1:0]        prob_in;
    logic [1:0]        prob_out;
    logic              out_valid;
    logic              out_ready;
    logic [SEED_W-1:0] out_seed;
    logic [SEED_W-1:0] rnd_in;
    logic              abort;
    logic              busy;
    logic              done;

    modport master (
        output load_valid, load_seed, load_count, prob_in, out_ready, rnd_in, abort,
        input  load_ready, prob_out, out_valid, out_seed, busy, done
    );

    modport slave (
        input  load_valid, load_seed, load_count, prob_in, out_ready, rnd_in, abort,
        output load_ready, prob_out, out_valid, out_seed, busy, done
    );
endinterface

// File: rtl/lfsr_seed_stepper.sv
// Seed register and burst sequencer in front of the combinational LFSR/probability-mask step.
// Optional feature macro: LFSR_STEP_PROB_LATCH_EN (latch prob_in at load and hold it for the burst).
module lfsr_seed_stepper #(
    parameter int RND_SIZE = 5,
    parameter int CNT_W    = 8,
    localparam int SEED_W  = RND_SIZE * (RND_SIZE - 1) / 2,
    parameter logic [SEED_W-1:0] DEFAULT_SEED = 'h001,
    parameter logic [1:0]        PROB_DEFAULT = 2'b00
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_seed_stepper_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [SEED_W-1:0] seed_reg;
    logic [CNT_W-1:0]  remaining_reg;
    logic              load_fire;
    logic              out_fire;

    assign load_fire = bus.load_valid && (state_reg == IDLE);
    // abort wins over a simultaneous transfer: the beat is consumed downstream but not stepped here
    assign out_fire  = (state_reg == RUN) && bus.out_ready && !bus.abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (load_fire) begin
                    state_next = (bus.load_count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (out_fire && remaining_reg <= CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready = (state_reg == IDLE);
        bus.out_valid  = (state_reg == RUN);
        bus.done       = (state_reg == DONE);
        bus.busy       = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_reg      <= DEFAULT_SEED;
            remaining_reg <= '0;
        end else if (load_fire) begin
            // an all-zero seed would lock the LFSR, so substitute the default
            seed_reg      <= (bus.load_seed == '0) ? DEFAULT_SEED : bus.load_seed;
            remaining_reg <= bus.load_count;
        end else if (out_fire) begin
            seed_reg <= bus.rnd_in;
            if (remaining_reg != '0) begin
                remaining_reg <= remaining_reg - CNT_W'(1);
            end
        end
    end

    assign bus.out_seed = seed_reg;

`ifdef LFSR_STEP_PROB_LATCH_EN
    logic [1:0] prob_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            prob_reg <= PROB_DEFAULT;
        end else if (load_fire) begin
            prob_reg <= bus.prob_in;
        end
    end

    assign bus.prob_out = prob_reg;
`else
    logic unused_prob_in;

    assign unused_prob_in = ^bus.prob_in;
    assign bus.prob_out   = PROB_DEFAULT;
`endif

endmodule
